// File: rtl/system_button_poller_if.sv
// Avalon-MM read port between the button poller
// and the input PIO s1 slave.
interface system_button_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata
  );
endinterface

// File: rtl/system_button_poller.sv
// Polls the button PIO, debounces each bit, emits press/release strobes.
// Define BUTTON_POLLER_IRQ_EN to build the sticky irq flag.
module system_button_poller #(
  parameter int POLL_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  system_button_poller_if.master        bus,
  output logic [7:0]                    buttons,
  output logic [7:0]                    press,
  output logic [7:0]                    release_stb,
  output logic                          irq,
  input  logic                          irq_ack
);

  localparam int DW = $clog2(POLL_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(POLL_DIV - 1);
  localparam logic [3:0] DC = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    CAPTURE
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [1:0]    wcnt;
  logic [7:0]    cand;
  logic [7:0]    cand_nx;
  logic [7:0]    flip;
  logic [7:0]    s;
  logic [3:0]    cnt    [8];
  logic [3:0]    cnt_nx [8];
  logic [23:0]   unused_rd;

  assign bus.avm_address = 2'd0;
  assign unused_rd = bus.avm_readdata[31:8];

  assign s = ACTIVE_LOW ? ~bus.avm_readdata[7:0]
                        : bus.avm_readdata[7:0];

  // A bit flips only once its candidate has been seen DC polls in a row.
  always_comb begin
    cand_nx = cand;
    flip    = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_nx[i] = cnt[i];
      if (s[i] == buttons[i]) begin
        cnt_nx[i] = 4'd0;
      end else if (s[i] == cand[i]) begin
        cnt_nx[i] = (cnt[i] == DC) ? cnt[i]
                                   : cnt[i] + 4'd1;
      end else begin
        cand_nx[i] = s[i];
        cnt_nx[i]  = 4'd1;
      end
      if (cnt_nx[i] == DC) begin
        flip[i]   = 1'b1;
        cnt_nx[i] = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div          <= DIV_LOAD;
      wcnt         <= 2'd0;
      bus.avm_read <= 1'b0;
      cand         <= '0;
      cnt          <= '{default: 4'd0};
      buttons      <= '0;
      press        <= '0;
      release_stb  <= '0;
    end else begin
      press       <= '0;
      release_stb <= '0;
      // Free-running so poll starts stay POLL_DIV apart.
      div <= (div == '0) ? DIV_LOAD
                         : div - 1'b1;
      unique case (state)
        IDLE: begin
          if (div == '0) begin
            state        <= READ;
            bus.avm_read <= 1'b1;
          end
        end
        READ: begin
          bus.avm_read <= 1'b0;
          if (READ_LATENCY == 1) begin
            state <= CAPTURE;
          end else begin
            state <= WAIT;
            wcnt  <= 2'(READ_LATENCY - 2);
          end
        end
        WAIT: begin
          if (wcnt == 2'd0) state <= CAPTURE;
          else              wcnt  <= wcnt - 2'd1;
        end
        CAPTURE: begin
          state       <= IDLE;
          cand        <= cand_nx;
          cnt         <= cnt_nx;
          buttons     <= buttons ^ flip;
          press       <= flip & s;
          release_stb <= flip & ~s;
        end
      endcase
    end
  end

`ifdef BUTTON_POLLER_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if ((press | release_stb) != 8'h00) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_system_button_poller.sv
// Scoreboard bench for system_button_poller: a fast-poll instance
// (latency 1, debounce 4) and a latency-3 instance (debounce 1).
module tb_system_button_poller;

`ifdef BUTTON_POLLER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] b;
    int         c;
  } ev_t;

  logic clk;
  logic reset;
  logic [7:0] btn1, prs1, rel1;
  logic [7:0] btn3, prs3, rel3;
  logic irq1, irq3, ack1, ack3;
  logic [31:0] pio;
  logic en3;
  logic r1, r2, r3;
  int cyc;
  int errors;
  int checks;
  int last_rd;
  logic prev_rd;
  ev_t sb[$];
  ev_t e;

  system_button_poller_if bus1 ();
  system_button_poller_if bus3 ();

  system_button_poller #(
    .POLL_DIV(8), .DEBOUNCE_CNT(4),
    .ACTIVE_LOW(1'b1), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus1),
    .buttons(btn1), .press(prs1),
    .release_stb(rel1), .irq(irq1),
    .irq_ack(ack1)
  );

  system_button_poller #(
    .POLL_DIV(8), .DEBOUNCE_CNT(1),
    .ACTIVE_LOW(1'b1), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .buttons(btn3), .press(prs3),
    .release_stb(rel3), .irq(irq3),
    .irq_ack(ack3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Registered-readdata PIO slave
  always @(posedge clk or posedge reset) begin
    if (reset)              bus1.avm_readdata <= 32'hFFFF_FFFF;
    else if (bus1.avm_read) bus1.avm_readdata <= pio;
  end

  // Latency-3 slave: bit2 pressed at T+1, bit1 pressed at T+2..T+3
  always @(posedge clk or posedge reset) begin
    if (reset) {r3, r2, r1} <= 3'b000;
    else       {r3, r2, r1} <= {r2, r1, bus3.avm_read};
  end

  always_comb begin
    bus3.avm_readdata = 32'hFFFF_FFFF;
    if (en3 && r1)              bus3.avm_readdata = 32'hFFFF_FFFB;
    else if (en3 && (r2 || r3)) bus3.avm_readdata = 32'hFFFF_FFFD;
  end

  initial last_rd = 0;
  initial prev_rd = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      last_rd = 0;
      prev_rd = 1'b0;
    end else begin
      if (bus1.avm_read) begin
        checks++;
        if (prev_rd || (cyc - last_rd) != 8 ||
            bus1.avm_address !== 2'd0) begin
          errors++;
          $display("FAIL poll_timing: read cyc=%0d prev=%0b addr=%0d, required cyc=%0d prev=0 addr=0",
                   cyc, prev_rd, bus1.avm_address, last_rd + 8);
        end
        last_rd = cyc;
      end
      prev_rd = bus1.avm_read;
      if ((prs1 | rel1) != 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: press=%h rel=%h btn=%h cyc=%0d, required no strobe",
                   prs1, rel1, btn1, cyc);
        end else begin
          e = sb.pop_front();
          if (prs1 !== e.p || rel1 !== e.r ||
              btn1 !== e.b || cyc != e.c) begin
            errors++;
            $display("FAIL strobe: press=%h rel=%h btn=%h cyc=%0d, required press=%h rel=%h btn=%h cyc=%0d",
                     prs1, rel1, btn1, cyc, e.p, e.r, e.b, e.c);
          end
        end
      end
    end
  end

  task automatic push_ev(input logic [7:0] p, input logic [7:0] r,
                         input logic [7:0] b, input int c);
    ev_t x;
    x.p = p;
    x.r = r;
    x.b = b;
    x.c = c;
    sb.push_back(x);
  endtask

  // Returns one cycle after the read strobe, once the slave has latched v.
  task automatic do_poll(input logic [31:0] v, output int pc);
    bit seen;
    seen = 1'b0;
    pc   = -1;
    pio  = v;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus1.avm_read) begin
        seen = 1'b1;
        pc   = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL poll_timeout: no avm_read in 20 cycles, required one");
    end
    @(negedge clk);
  endtask

  task automatic polls(input logic [31:0] v, input int n, output int pc);
    for (int i = 0; i < n; i++) do_poll(v, pc);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.avm_read, bus1.avm_address, btn1, prs1, rel1, irq1}
        !== 28'd0) begin
      errors++;
      $display("FAIL reset_dut1: rd=%b addr=%0d btn=%h p=%h r=%h irq=%b, required all 0",
               bus1.avm_read, bus1.avm_address, btn1, prs1, rel1, irq1);
    end
    checks++;
    if ({bus3.avm_read, bus3.avm_address, btn3, prs3, rel3, irq3}
        !== 28'd0) begin
      errors++;
      $display("FAIL reset_dut3: rd=%b addr=%0d btn=%h p=%h r=%h irq=%b, required all 0",
               bus3.avm_read, bus3.avm_address, btn3, prs3, rel3, irq3);
    end
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus1.avm_read) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != 8) begin
      errors++;
      $display("FAIL first_read: seen=%0b cyc=%0d, required seen=1 cyc=8",
               seen, cyc);
    end
    @(negedge clk);
    checks++;
    if (bus1.avm_read !== 1'b0) begin
      errors++;
      $display("FAIL read_width: avm_read=%b one cycle later, required 0",
               bus1.avm_read);
    end
  endtask

  task automatic test_latency3();
    bit seen;
    logic [7:0] eb, ep, er;
    logic erd;
    repeat (4) @(negedge clk);
    en3  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus3.avm_read) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL lat3_read: no avm_read in 20 cycles, required one");
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) en3 = 1'b0;
      eb  = (k >= 4 && k < 12) ? 8'h02 : 8'h00;
      ep  = (k == 4)  ? 8'h02 : 8'h00;
      er  = (k == 12) ? 8'h02 : 8'h00;
      erd = (k == 8);
      checks++;
      if ({bus3.avm_read, btn3, prs3, rel3} !== {erd, eb, ep, er}) begin
        errors++;
        $display("FAIL lat3 T+%0d: rd=%b btn=%h p=%h r=%h, required rd=%b btn=%h p=%h r=%h",
                 k, bus3.avm_read, btn3, prs3, rel3, erd, eb, ep, er);
      end
    end
  endtask

  task automatic test_press();
    int pc;
    polls(32'hFFFF_FFFE, 4, pc);
    push_ev(8'h01, 8'h00, 8'h01, pc + 2);
    settle();
    checks++;
    if (btn1 !== 8'h01 || prs1 !== 8'h00 || rel1 !== 8'h00) begin
      errors++;
      $display("FAIL press_hold: btn=%h p=%h r=%h, required btn=01 p=00 r=00",
               btn1, prs1, rel1);
    end
  endtask

  task automatic test_glitch();
    int pc;
    do_poll(32'hFFFF_FFFC, pc);
    do_poll(32'hFFFF_FFFE, pc);
    polls(32'hFFFF_FFFC, 3, pc);
    @(negedge clk);
    checks++;
    if (btn1 !== 8'h01) begin
      errors++;
      $display("FAIL glitch: btn=%h, required 01", btn1);
    end
    do_poll(32'hFFFF_FFFE, pc);
  endtask

  task automatic test_release();
    int pc;
    polls(32'hDEAD_BEFF, 4, pc);
    push_ev(8'h00, 8'h01, 8'h00, pc + 2);
    settle();
    checks++;
    if (btn1 !== 8'h00 || rel1 !== 8'h00) begin
      errors++;
      $display("FAIL release_hold: btn=%h r=%h, required btn=00 r=00",
               btn1, rel1);
    end
  endtask

  task automatic test_back_to_back();
    int pc;
    polls(32'hFFFF_FFD7, 4, pc);
    push_ev(8'h28, 8'h00, 8'h28, pc + 2);
    polls(32'hFFFF_FF5F, 4, pc);
    push_ev(8'h80, 8'h08, 8'hA0, pc + 2);
    polls(32'hFFFF_FFFF, 4, pc);
    push_ev(8'h00, 8'hA0, 8'h00, pc + 2);
    settle();
  endtask

  task automatic test_irq();
    int pc;
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    checks++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear0: irq=%b, required 0", irq1);
    end
    polls(32'hFFFF_FFEF, 4, pc);
    push_ev(8'h10, 8'h00, 8'h10, pc + 2);
    settle();
    checks++;
    if (irq1 !== IRQ_EN) begin
      errors++;
      $display("FAIL irq_set: irq=%b, required %b", irq1, IRQ_EN);
    end
    polls(32'hFFFF_FFAF, 4, pc);
    push_ev(8'h40, 8'h00, 8'h50, pc + 2);
    @(negedge clk);
    ack1 = 1'b1;
    checks++;
    if (irq1 !== IRQ_EN) begin
      errors++;
      $display("FAIL irq_pre_ack: irq=%b, required %b", irq1, IRQ_EN);
    end
    @(negedge clk);
    ack1 = 1'b0;
    checks++;
    if (irq1 !== IRQ_EN) begin
      errors++;
      $display("FAIL irq_set_wins: irq=%b, required %b", irq1, IRQ_EN);
    end
    @(negedge clk);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    checks++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack: irq=%b, required 0", irq1);
    end
    polls(32'hFFFF_FFFF, 4, pc);
    push_ev(8'h00, 8'h50, 8'h00, pc + 2);
    settle();
  endtask

  task automatic test_reset_midpoll();
    int pc;
    bit seen;
    polls(32'hFFFF_FFFE, 4, pc);
    push_ev(8'h01, 8'h00, 8'h01, pc + 2);
    polls(32'hFFFF_FFFF, 3, pc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus1.avm_read) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || {bus1.avm_read, btn1, prs1, rel1, irq1} !== 26'd0) begin
      errors++;
      $display("FAIL midpoll_reset: seen=%0b rd=%b btn=%h p=%h r=%h irq=%b, required seen=1 all 0",
               seen, bus1.avm_read, btn1, prs1, rel1, irq1);
    end
    @(negedge clk);
    reset = 1'b0;
    polls(32'hFFFF_FFFE, 3, pc);
    @(negedge clk);
    checks++;
    if (btn1 !== 8'h00) begin
      errors++;
      $display("FAIL midpoll_count: btn=%h after 3 polls, required 00", btn1);
    end
    do_poll(32'hFFFF_FFFE, pc);
    push_ev(8'h01, 8'h00, 8'h01, pc + 2);
    settle();
    checks++;
    if (btn1 !== 8'h01) begin
      errors++;
      $display("FAIL midpoll_press: btn=%h, required 01", btn1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    pio    = 32'hFFFF_FFFF;
    en3    = 1'b0;
    ack1   = 1'b0;
    ack3   = 1'b0;
    test_reset();
    test_latency3();
    test_press();
    test_glitch();
    test_release();
    test_back_to_back();
    test_irq();
    test_reset_midpoll();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/system_button_poller.md
Name: system_button_poller

Overview:
- Avalon-MM read initiator that periodically polls the system's 8-bit input PIO (buttons) over its s1 slave interface.
- Per-bit debouncing of the polled value; produces stable button levels plus single-cycle press/release strobes for the clock/alarm control logic.
- Sits between the input PIO slave (address 0 = data register, registered readdata) and the alarm-setting FSM.

Parameters:
- POLL_DIV, 5000, clk cycles between poll starts; legal range 4..2^20.
- DEBOUNCE_CNT, 4, consecutive identical polls required before a bit's stable value changes; legal range 1..15.
- ACTIVE_LOW, 1, 1 = raw PIO bit 0 means pressed, so the raw value is inverted before debounce.
- READ_LATENCY, 1, cycles from read-issue cycle to the cycle where avm_readdata is captured; legal range 1..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avm_address  out  2  slave word address; always 0.
- avm_read  out  1  read strobe, one cycle per poll.
- avm_readdata  in  32  slave read data; only [7:0] used, [31:8] ignored.
- buttons  out  8  debounced levels, 1 = pressed.
- press  out  8  one-cycle strobe per bit on a 0->1 transition of buttons.
- release  out  8  one-cycle strobe per bit on a 1->0 transition of buttons.
- irq  out  1  sticky event flag; see Optional Feature.
- irq_ack  in  1  clears irq.

Behaviour:
- Reset values (async, while reset=1):
  - avm_read=0, avm_address=0, buttons=0, press=0, release=0, irq=0.
  - FSM=IDLE, divider=POLL_DIV-1, all debounce counters=0, candidate values=0.
- FSM states:
  - IDLE: divider decrements each cycle. At 0, go to READ and reload POLL_DIV-1.
  - READ: avm_read=1 for exactly one cycle, then go to WAIT. avm_address is held at 0 in all states.
  - WAIT: stays for READ_LATENCY-1 cycles; with READ_LATENCY=1, passes straight through to CAPTURE on the next cycle.
  - CAPTURE: samples s = avm_readdata[7:0], inverted if ACTIVE_LOW. Updates debounce, then returns to IDLE.
- Poll period: the divider runs in all states. Poll starts are exactly POLL_DIV cycles apart, independent of READ_LATENCY. POLL_DIV must exceed READ_LATENCY+2.
- Debounce, per bit i, applied on the CAPTURE cycle:
  - if s[i]==buttons[i]: cnt[i]=0.
  - else if s[i]==cand[i]: cnt[i]=cnt[i]+1, saturating at DEBOUNCE_CNT.
  - else: cand[i]=s[i], cnt[i]=1.
  - When the updated cnt[i] reaches DEBOUNCE_CNT: buttons[i] takes s[i] on the following clock and cnt[i] clears.
- Strobes: press/release are registered. They assert in the same cycle buttons changes, for exactly one cycle. Multiple bits may strobe together.
- No waitrequest exists: the slave is fixed-latency, and data is taken unconditionally in CAPTURE.
- Reset mid-poll (any state) returns everything to reset values. No partial sample is retained.
- DEBOUNCE_CNT=1: a single differing poll changes buttons.

Optional Feature:
- Macro: BUTTON_POLLER_IRQ_EN.
- Defined:
  - irq sets on any cycle where press or release is non-zero.
  - irq clears on irq_ack=1.
  - Set wins over clear when both occur in the same cycle.
- Undefined: irq is constant 0 and irq_ack is ignored; no irq flop is synthesised.

Test Plan:
- Reset then idle, POLL_DIV=8, READ_LATENCY=1 -> first avm_read at cycle 8 after reset deasserts, then every 8 cycles, each exactly 1 cycle wide, with avm_address=0 throughout.
- Slave drives readdata=0xFE (bit0 low, ACTIVE_LOW=1), DEBOUNCE_CNT=4 -> buttons=0x01 one cycle after the 4th capture; press=0x01 for exactly one cycle; release=0.
- Bit 0 glitches low, high, low, low across four polls, DEBOUNCE_CNT=4 -> buttons stays 0x00 (count restarts after the high sample).
- Held press released (readdata back to 0xFF) -> after 4 polls buttons=0x00 and release=0x01 for one cycle. readdata[31:8]=0xDEADBE has no effect.
- READ_LATENCY=3, slave readdata changes 2 cycles after avm_read -> CAPTURE samples the value present 3 cycles after avm_read; poll period unchanged.
- BUTTON_POLLER_IRQ_EN defined: a press sets irq; irq_ack asserted in the same cycle as a second press strobe -> irq stays 1; a later ack clears it. Without the macro, irq=0 throughout.
